// File: rtl/dynamic_mac_pkg.sv
// dynamic_mac_pkg: opcode type and decode helpers shared by the multiply-accumulate datapath
package dynamic_mac_pkg;
  typedef enum logic [1:0] {
    OP_ADD_C   = 2'b00,
    OP_SUB_C   = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } mac_op_e;

  function automatic logic is_acc(input mac_op_e op);
    return op[1];
  endfunction

  function automatic logic is_sub(input mac_op_e op);
    return op[0];
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one lane's product stage, add/subtract stage and accumulator (DYNAMIC_MODE_MAC_SAT_EN clamps on overflow)
module mac_lane
  import dynamic_mac_pkg::*;
#(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int CW = 32,
  parameter int PW = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_i,
  input  logic                 fire_i,
  input  logic signed [AW-1:0] a_i,
  input  logic signed [BW-1:0] b_i,
  input  logic signed [CW-1:0] c_i,
  input  mac_op_e              op_i,
  input  logic                 clr_i,
  output logic signed [PW-1:0] pout_o,
  output logic                 sat_o
);
  logic signed [AW+BW-1:0] prod_q;
  logic signed [PW-1:0]    c_q, acc_q, term, prod_x, res_d;
  logic [PW:0]             sum;
  mac_op_e                 op_q;
  logic                    clr_q, ovf, sat_q;

  // the output register doubles as the accumulator: every beat leaving the lane loads both
  assign term   = is_acc(op_q) ? (clr_q ? '0 : acc_q) : c_q;
  assign prod_x = PW'(prod_q);
  assign sum    = is_sub(op_q) ? {term[PW-1], term} - {prod_x[PW-1], prod_x}
                               : {term[PW-1], term} + {prod_x[PW-1], prod_x};
  assign ovf    = sum[PW] ^ sum[PW-1];
`ifdef DYNAMIC_MODE_MAC_SAT_EN
  assign res_d  = ovf ? (sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}}) : sum[PW-1:0];
`else
  assign res_d  = sum[PW-1:0];
`endif
  assign pout_o = acc_q;
  assign sat_o  = sat_q;

  // S2: multiply and sign-extend C, advancing with the shared pipeline enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod_q <= '0;
      c_q    <= '0;
      op_q   <= OP_ADD_C;
      clr_q  <= 1'b0;
    end else if (ce_i) begin
      prod_q <= (AW+BW)'(a_i) * (AW+BW)'(b_i);
      c_q    <= PW'(c_i);
      op_q   <= op_i;
      clr_q  <= clr_i;
    end

  // S3: only valid beats update result, accumulator and overflow flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (fire_i) begin
      acc_q <= res_d;
      sat_q <= ovf;
    end
endmodule

// File: rtl/dynamic_mode_mac.sv
// dynamic_mode_mac: NCH-lane 3-stage signed multiply-add/accumulate with valid/ready (DYNAMIC_MODE_MAC_SAT_EN selects saturation)
module dynamic_mode_mac
  import dynamic_mac_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int BW  = 16,
  parameter int CW  = 32,
  parameter int PW  = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic              acc_clr,
  input  logic [NCH*AW-1:0] ain,
  input  logic [NCH*BW-1:0] bin,
  input  logic [NCH*CW-1:0] cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*PW-1:0] pout,
  output logic [NCH-1:0]    sat_flag
);
  logic              ce, v1_q, v2_q, ov_q, clr_q;
  logic [NCH*AW-1:0] a_q;
  logic [NCH*BW-1:0] b_q;
  logic [NCH*CW-1:0] c_q;
  mac_op_e           op_q;

  assign ce        = !ov_q || out_ready;
  assign in_ready  = ce;
  assign out_valid = ov_q;

  // S1 operand capture and stage valids, all frozen together while the output is stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      op_q  <= OP_ADD_C;
      clr_q <= 1'b0;
    end else if (ce) begin
      v1_q  <= in_valid;
      v2_q  <= v1_q;
      ov_q  <= v2_q;
      a_q   <= ain;
      b_q   <= bin;
      c_q   <= cin;
      op_q  <= mac_op_e'(op);
      clr_q <= acc_clr;
    end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    mac_lane #(.AW(AW), .BW(BW), .CW(CW), .PW(PW)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce_i   (ce),
      .fire_i (ce && v2_q),
      .a_i    (a_q[i*AW +: AW]),
      .b_i    (b_q[i*BW +: BW]),
      .c_i    (c_q[i*CW +: CW]),
      .op_i   (op_q),
      .clr_i  (clr_q),
      .pout_o (pout[i*PW +: PW]),
      .sat_o  (sat_flag[i])
    );
  end
endmodule

// File: tb/tb_dynamic_mode_mac.sv
// tb_dynamic_mode_mac: random and directed checks of dynamic_mode_mac against a behavioural scoreboard model
module tb_dynamic_mode_mac;
  localparam int NCH = 4, AW = 16, BW = 16, CW = 32, PW = 33;
  localparam longint PMAX = (64'sd1 <<< (PW-1)) - 1;
  localparam longint PMIN = -(64'sd1 <<< (PW-1));
  localparam longint MASK = (64'sd1 <<< PW) - 1;

  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, acc_clr = 0, out_valid, out_ready = 1;
  logic [1:0] op = 0;
  logic [NCH*AW-1:0] ain = '0;
  logic [NCH*BW-1:0] bin = '0;
  logic [NCH*CW-1:0] cin = '0;
  logic [NCH*PW-1:0] pout;
  logic [NCH-1:0] sat_flag;

  typedef struct packed {
    logic [NCH*PW-1:0] p;
    logic [NCH-1:0]    s;
  } exp_t;

  exp_t   exp_q[$];
  longint got_q[$];
  logic   gsat_q[$];
  longint acc_m[NCH];
  int     checks = 0, errs = 0;
  bit     rnd_on = 0;

  dynamic_mode_mac #(.NCH(NCH), .AW(AW), .BW(BW), .CW(CW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_clr(acc_clr), .ain(ain), .bin(bin), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .pout(pout), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint ex);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask

  function automatic longint lane(input logic [NCH*PW-1:0] v, input int l);
    logic signed [PW-1:0] t;
    t = v[l*PW +: PW];
    return longint'(t);
  endfunction

  // exact integer arithmetic on the beat about to be accepted, then wrap or clamp to PW bits
  function automatic exp_t model();
    exp_t e;
    logic signed [AW-1:0] av;
    logic signed [BW-1:0] bv;
    logic signed [CW-1:0] cv;
    longint t, s, w;
    bit ov;
    for (int l = 0; l < NCH; l++) begin
      av = ain[l*AW +: AW];
      bv = bin[l*BW +: BW];
      cv = cin[l*CW +: CW];
      t = op[1] ? (acc_clr ? 64'sd0 : acc_m[l]) : longint'(cv);
      s = op[0] ? t - longint'(av) * longint'(bv) : t + longint'(av) * longint'(bv);
      ov = (s > PMAX) || (s < PMIN);
      w = s & MASK;
      if (w > PMAX) w = w - (64'sd1 <<< PW);
`ifdef DYNAMIC_MODE_MAC_SAT_EN
      if (ov) w = (s > PMAX) ? PMAX : PMIN;
`endif
      acc_m[l] = w;
      e.p[l*PW +: PW] = w[PW-1:0];
      e.s[l] = ov;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int l = 0; l < NCH; l++) acc_m[l] = 0;
      chk(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_out_beat", 1, 0);
        else begin
          for (int l = 0; l < NCH; l++)
            chk(lane(pout, l) == lane(exp_q[0].p, l), $sformatf("pout_lane%0d", l), lane(pout, l), lane(exp_q[0].p, l));
          chk(sat_flag == exp_q[0].s, "sat_flag", longint'(sat_flag), longint'(exp_q[0].s));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(lane(pout, 0));
            gsat_q.push_back(sat_flag[0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model());
    end
  end

  task automatic drive(input logic [1:0] o, input bit clr, input longint a, input longint b, input longint c, input bit rnd);
    in_valid = 1;
    op = rnd ? 2'($urandom) : o;
    acc_clr = rnd ? 1'($urandom_range(0, 3) == 0) : clr;
    for (int l = 0; l < NCH; l++) begin
      ain[l*AW +: AW] = rnd ? AW'($urandom) : AW'(a);
      bin[l*BW +: BW] = rnd ? BW'($urandom) : BW'(b);
      cin[l*CW +: CW] = rnd ? CW'($urandom) : CW'(c);
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n == 299) chk(1'b0, "in_ready_timeout", 0, 1);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
      if (n == 499) chk(1'b0, "drain_timeout", longint'(exp_q.size()), 0);
    end
    #1;
  endtask

  always begin
    @(posedge clk);
    #1 if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, lat;
    repeat (3) @(posedge clk);
    #1;
    chk(pout == '0, "reset_pout", lane(pout, 0), 0);
    chk(sat_flag == '0, "reset_sat", longint'(sat_flag), 0);
    chk(out_valid == 1'b0, "reset_valid", longint'(out_valid), 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    idx = got_q.size();
    drive(2'b00, 0, 3, -4, 10, 0);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk(lat == 3, "latency_negedges", lat, 3);
    drain();
    chk(got_q.size() > idx && got_q[idx] == -2, "t1_add_c", got_q.size() > idx ? got_q[idx] : 0, -2);
    chk(got_q.size() > idx && gsat_q[idx] == 1'b0, "t1_sat", 0, 0);

    idx = got_q.size();
    repeat (4) drive(2'b01, 0, -5, 6, -7, 0);
    drain();
    chk(got_q.size() == idx + 4, "t2_count", got_q.size() - idx, 4);
    for (int k = 0; k < 4 && idx + k < got_q.size(); k++) chk(got_q[idx+k] == 23, "t2_sub_c", got_q[idx+k], 23);

    idx = got_q.size();
    drive(2'b00, 0, 1, 1, 0, 0);
    repeat (3) drive(2'b10, 0, 2, 3, 0, 0);
    drain();
    chk(got_q.size() == idx + 4, "t3_count", got_q.size() - idx, 4);
    for (int k = 0; k < 4 && idx + k < got_q.size(); k++) chk(got_q[idx+k] == 1 + 6*k, "t3_acc_chain", got_q[idx+k], 1 + 6*k);

    idx = got_q.size();
    drive(2'b11, 1, 4, 4, 0, 0);
    drive(2'b10, 0, 1, 16, 0, 0);
    drain();
    chk(got_q.size() == idx + 2 && got_q[idx] == -16, "t4_acc_clr", got_q.size() > idx ? got_q[idx] : 0, -16);
    chk(got_q.size() == idx + 2 && got_q[idx+1] == 0, "t4_acc_add", got_q.size() > idx + 1 ? got_q[idx+1] : 0, 0);

    idx = got_q.size();
    fork
      repeat (6) drive(2'b00, 0, 0, 0, 0, 1);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 chk(in_ready == 1'b0, "t5_in_ready_low", longint'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk(got_q.size() == idx + 6, "t5_count", got_q.size() - idx, 6);

    idx = got_q.size();
    drive(2'b00, 0, -32768, -32768, 32'h7FFFFFFF, 0);
    repeat (2) drive(2'b10, 0, -32768, -32768, 0, 0);
    drain();
    chk(got_q.size() == idx + 3, "t6_count", got_q.size() - idx, 3);
    if (got_q.size() == idx + 3) begin
      chk(got_q[idx] == 64'sd3221225471, "t6_seed", got_q[idx], 64'sd3221225471);
      chk(got_q[idx+1] == 64'sd4294967295 && gsat_q[idx+1] == 1'b0, "t6_max_no_sat", got_q[idx+1], 64'sd4294967295);
`ifdef DYNAMIC_MODE_MAC_SAT_EN
      chk(got_q[idx+2] == 64'sd4294967295, "t6_clamp", got_q[idx+2], 64'sd4294967295);
`else
      chk(got_q[idx+2] == -64'sd3221225473, "t6_wrap", got_q[idx+2], -64'sd3221225473);
`endif
      chk(gsat_q[idx+2] == 1'b1, "t6_sat_flag", longint'(gsat_q[idx+2]), 1);
    end

    rnd_on = 1;
    for (int k = 0; k < 300; k++) begin
      drive(2'b00, 0, 0, 0, 0, 1);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rnd_on = 0;
    #1 out_ready = 1;
    drain();

    drive(2'b00, 0, 5, 5, 0, 0);
    drive(2'b10, 0, 1, 1, 0, 0);
    rst_n = 0;
    #1;
    chk(out_valid == 1'b0, "midrst_out_valid", longint'(out_valid), 0);
    chk(pout == '0, "midrst_pout", lane(pout, 0), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idx = got_q.size();
    repeat (6) @(posedge clk);
    #1;
    chk(got_q.size() == idx, "midrst_no_output", got_q.size() - idx, 0);
    drive(2'b10, 0, 2, 3, 0, 0);
    drain();
    chk(got_q.size() == idx + 1 && got_q[idx] == 6, "midrst_acc_cleared", got_q.size() > idx ? got_q[idx] : 0, 6);
    chk(exp_q.size() == 0, "final_pending", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
